gpio_irq_ctrl: RTL

Parametrised GPIO controller for the RISC-V cache SoC peripheral region at ADDR_GPIO. It is the successor to the fixed 8-in/8-out GPIO used for keypad testing. It adds:
- configurable pin count
- per-pin direction
- input synchronisation and optional debounce
- rising/falling edge interrupts with write-1-to-clear pending bits

It connects to the peripheral interconnect over a zero-wait APB slave port and drives the GPIO line into the PIC.

---
 rtl/gpio_irq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: parametrised GPIO block with an APB slave port.
// Each pin has its own direction, a two-flop input synchroniser and
// optional tick-based debounce. Rising and falling edges on the
// debounced value latch into write-1-to-clear pending bits, and irq is
// the OR of those bits.
module gpio_irq_ctrl #(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] OFF_DATA_IN  = 3'd0;
  localparam logic [2:0] OFF_DATA_OUT = 3'd1;
  localparam logic [2:0] OFF_DIR      = 3'd2;
  localparam logic [2:0] OFF_RISE_EN  = 3'd3;
  localparam logic [2:0] OFF_FALL_EN  = 3'd4;
  localparam logic [2:0] OFF_PENDING  = 3'd5;
  localparam logic [2:0] OFF_DB_EN    = 3'd6;

  logic [GPIO_WIDTH-1:0] data_out_q, dir_q, rise_en_q, fall_en_q, pending_q, db_en_q;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, samp_q, stable_q;
  logic [GPIO_WIDTH-1:0] samp_upd, accept, next_samp, next_stable;
  logic [GPIO_WIDTH-1:0] rise, fall, set_bits, clr_bits, wdata, rd_val;
  logic [CNT_W-1:0]      tick_cnt_q;
  logic                  tick;
  logic [2:0]            word_sel;
  logic                  in_window, mapped, access, wr_en;
  logic                  unused_bits;

  // Address decode: only word offsets 0x00..0x18 in the low 32 bytes are backed
  assign word_sel    = paddr[4:2];
  assign in_window   = (paddr[ADDR_WIDTH-1:5] == '0);
  assign mapped      = in_window && (word_sel != 3'd7);
  assign access      = psel && penable;
  assign wr_en       = access && pwrite && mapped;
  assign wdata       = pwdata[GPIO_WIDTH-1:0];
  assign pready      = 1'b1;
  assign pslverr     = access && !mapped;
  assign unused_bits = ^{paddr[1:0], pwdata};

  // Read mux over the register file; unmapped offsets and idle bus read 0
  always_comb begin
    rd_val = '0;
    case (word_sel)
      OFF_DATA_IN:  rd_val = stable_q;
      OFF_DATA_OUT: rd_val = data_out_q;
      OFF_DIR:      rd_val = dir_q;
      OFF_RISE_EN:  rd_val = rise_en_q;
      OFF_FALL_EN:  rd_val = fall_en_q;
      OFF_PENDING:  rd_val = pending_q;
      OFF_DB_EN:    rd_val = db_en_q;
      default:      rd_val = '0;
    endcase
    prdata = (psel && !pwrite && mapped) ? 32'(rd_val) : 32'd0;
  end

  // Free-running debounce tick counter shared by every pin
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn)
      tick_cnt_q <= '0;
    else if (tick)
      tick_cnt_q <= '0;
    else
      tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Debounced pins resample on tick and accept a level seen on two ticks
  // in a row; non-debounced pins follow the synchroniser every cycle
  assign samp_upd    = {GPIO_WIDTH{tick}} & db_en_q;
  assign next_samp   = (samp_q & ~samp_upd) | (sync2_q & samp_upd);
  assign accept      = ~db_en_q | (samp_upd & ~(sync2_q ^ samp_q));
  assign next_stable = (stable_q & ~accept) | (sync2_q & accept);

  // Edges are taken against the value stable is about to load
  assign rise     = ~stable_q & next_stable;
  assign fall     = stable_q & ~next_stable;
  assign set_bits = (rise & rise_en_q) | (fall & fall_en_q);
  assign clr_bits = (wr_en && (word_sel == OFF_PENDING)) ? wdata : '0;

  // Input synchroniser, debounce sample and stable value
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      samp_q   <= next_samp;
      stable_q <= next_stable;
    end
  end

  // Software-visible registers; a new edge beats a same-cycle W1C clear
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      db_en_q    <= '0;
      pending_q  <= '0;
    end else begin
      if (wr_en && (word_sel == OFF_DATA_OUT)) data_out_q <= wdata;
      if (wr_en && (word_sel == OFF_DIR))      dir_q      <= wdata;
      if (wr_en && (word_sel == OFF_RISE_EN))  rise_en_q  <= wdata;
      if (wr_en && (word_sel == OFF_FALL_EN))  fall_en_q  <= wdata;
      if (wr_en && (word_sel == OFF_DB_EN))    db_en_q    <= wdata;
      pending_q <= (pending_q & ~clr_bits) | set_bits;
    end
  end

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |pending_q;

endmodule
